// File: rtl/j1_uart_io.sv
// UART peripheral for the j1 CPU I/O port: 8N1 transmitter with one holding
// register, 8N1 receiver feeding a small FIFO, and a pollable status word.
`timescale 1ns/1ps
module j1_uart_io #(
  parameter int CLKS_PER_BIT = 104,
  parameter int RX_DEPTH     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_wdata,
  output logic [15:0] io_din,
  input  logic        uart_rx,
  output logic        uart_tx
);
  localparam int AW = $clog2(RX_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(RX_DEPTH);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  logic is_data, is_stat, rd_data, rd_stat, wr_data;
  logic unused_ok;

  assign is_data   = io_addr[12];
  assign is_stat   = io_addr[13] & ~io_addr[12];
  assign rd_data   = io_rd & is_data;
  assign rd_stat   = io_rd & is_stat;
  assign wr_data   = io_wr & is_data;
  assign unused_ok = ^{io_addr[15:14], io_addr[11:0], io_wdata[15:8]};

  // Transmitter: tx_bit 0 = start, 1..8 = data LSB first, 9 = stop.
  logic          tx_busy_q, tx_busy_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_out_q, tx_out_d;

  always_comb begin
    tx_busy_d = tx_busy_q;
    tx_cnt_d  = tx_cnt_q;
    tx_bit_d  = tx_bit_q;
    tx_data_d = tx_data_q;
    tx_out_d  = tx_out_q;
    if (tx_busy_q) begin
      if (tx_cnt_q == '0) begin
        if (tx_bit_q == 4'd9) begin
          tx_busy_d = 1'b0;
          tx_out_d  = 1'b1;
        end else begin
          tx_bit_d = tx_bit_q + 4'd1;
          tx_cnt_d = BIT_LAST;
          tx_out_d = (tx_bit_q == 4'd8) ? 1'b1 : tx_data_q[tx_bit_q[2:0]];
        end
      end else begin
        tx_cnt_d = tx_cnt_q - CW'(1);
      end
    end else if (wr_data) begin
      tx_busy_d = 1'b1;
      tx_data_d = io_wdata[7:0];
      tx_bit_d  = 4'd0;
      tx_cnt_d  = BIT_LAST;
      tx_out_d  = 1'b0;
    end
  end

  // Receiver
  logic          rx_s1_q, rx_s2_q, rxs;
  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bits_q, rx_bits_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_push, rx_frm_set;

  assign rxs = rx_s2_q;

  always_ff @(posedge clk) begin
    if (reset) rx_state_q <= RX_IDLE;
    else       rx_state_q <= rx_state_d;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      RX_IDLE:  if (!rxs) rx_state_d = RX_START;
      RX_START: if (rx_cnt_q == '0) rx_state_d = rxs ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_cnt_q == '0 && rx_bits_q == 3'd7) rx_state_d = RX_STOP;
      RX_STOP:  if (rx_cnt_q == '0) rx_state_d = RX_IDLE;
      default:  rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_cnt_d   = rx_cnt_q;
    rx_bits_d  = rx_bits_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    rx_frm_set = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d  = HALF_LAST;
        rx_bits_d = 3'd0;
      end
      RX_START: rx_cnt_d = (rx_cnt_q == '0) ? BIT_LAST : rx_cnt_q - CW'(1);
      RX_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_cnt_d   = BIT_LAST;
          rx_shift_d = {rxs, rx_shift_q[7:1]};
          rx_bits_d  = rx_bits_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q - CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == '0) begin
          rx_push    = rxs;
          rx_frm_set = ~rxs;
        end else begin
          rx_cnt_d = rx_cnt_q - CW'(1);
        end
      end
      default: ;
    endcase
  end

  // RX FIFO and sticky flags
  logic [7:0]  fifo_mem_q [RX_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic        fifo_empty, fifo_full, pop, push_ok, ovr_set;
  logic        ovr_q, ovr_d, frm_q, frm_d;
  logic [15:0] status, io_din_q, io_din_d;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_C);
  assign pop        = rd_data & ~fifo_empty;
  assign push_ok    = rx_push & (~fifo_full | pop);
  assign ovr_set    = rx_push & fifo_full & ~pop;
  assign status     = {12'h000, frm_q, ovr_q, ~fifo_empty, ~tx_busy_q};

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop);
    ovr_d    = ovr_set    | (ovr_q & ~rd_stat);
    frm_d    = rx_frm_set | (frm_q & ~rd_stat);
    io_din_d = io_din_q;
    if (io_rd) begin
      if (is_data)      io_din_d = fifo_empty ? 16'h0000 : {8'h00, fifo_mem_q[rd_ptr_q]};
      else if (is_stat) io_din_d = status;
      else              io_din_d = 16'h0000;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem_q[wr_ptr_q] <= rx_shift_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_busy_q  <= 1'b0;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 4'd0;
      tx_data_q  <= 8'h00;
      tx_out_q   <= 1'b1;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_cnt_q   <= '0;
      rx_bits_q  <= 3'd0;
      rx_shift_q <= 8'h00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovr_q      <= 1'b0;
      frm_q      <= 1'b0;
      io_din_q   <= 16'h0000;
    end else begin
      tx_busy_q  <= tx_busy_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_data_q  <= tx_data_d;
      tx_out_q   <= tx_out_d;
      rx_s1_q    <= uart_rx;
      rx_s2_q    <= rx_s1_q;
      rx_cnt_q   <= rx_cnt_d;
      rx_bits_q  <= rx_bits_d;
      rx_shift_q <= rx_shift_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovr_q      <= ovr_d;
      frm_q      <= frm_d;
      io_din_q   <= io_din_d;
    end
  end

  assign io_din  = io_din_q;
  assign uart_tx = tx_out_q;
endmodule

// File: tb/tb_j1_uart_io.sv
// Bench for j1_uart_io: decode vector table, then TX/RX/overrun/framing/reset
// sequences; read results are queued when the read is driven and checked on return.
`timescale 1ns/1ps
module tb_j1_uart_io;
  localparam int CPB   = 4;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset, io_rd, io_wr, uart_rx;
  logic [15:0] io_addr, io_wdata, io_din;
  logic        uart_tx;

  always #5 clk = ~clk;

  j1_uart_io #(.CLKS_PER_BIT(CPB), .RX_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .io_rd(io_rd), .io_wr(io_wr),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_din(io_din),
    .uart_rx(uart_rx), .uart_tx(uart_tx)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       nm;
    logic [15:0] exp;
  } sb_t;
  sb_t  sb[$];
  sb_t  mon_e;
  logic rd_seen = 1'b0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_din;
    logic        exp_tx;
  } vec_t;
  localparam int NV = 9;
  vec_t vec [NV];

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", nm, act, exp);
    end
  endtask

  task automatic expect_rd(input string nm, input logic [15:0] exp);
    sb_t e;
    e.nm  = nm;
    e.exp = exp;
    sb.push_back(e);
  endtask

  always @(posedge clk) rd_seen <= io_rd;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got read data 0x%04h expected no read", io_din);
      end else begin
        mon_e = sb.pop_front();
        check(mon_e.nm, io_din, mon_e.exp);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string nm);
    expect_rd(nm, exp);
    io_rd   = 1'b1;
    io_addr = a;
    @(negedge clk);
    io_rd   = 1'b0;
    io_addr = 16'h0000;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    io_wr    = 1'b1;
    io_addr  = a;
    io_wdata = d;
    @(negedge clk);
    io_wr    = 1'b0;
    io_addr  = 16'h0000;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      uart_rx = 1'b0;
      else if (i == 9) uart_rx = stop;
      else             uart_rx = b[i-1];
      tick(CPB);
    end
    uart_rx = 1'b1;
    tick(3);
  endtask

  logic [9:0] frame;

  initial begin
    vec[0] = '{1'b1, 1'b0, 16'h2000, 16'h0000, 16'h0001, 1'b1};
    vec[1] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1};
    vec[2] = '{1'b1, 1'b0, 16'h2FFF, 16'h0000, 16'h0001, 1'b1};
    vec[3] = '{1'b1, 1'b0, 16'h3000, 16'h0000, 16'h0000, 1'b1};
    vec[4] = '{1'b0, 1'b1, 16'h2000, 16'h00A5, 16'h0000, 1'b1};
    vec[5] = '{1'b1, 1'b0, 16'hE000, 16'h0000, 16'h0001, 1'b1};
    vec[6] = '{1'b1, 1'b0, 16'hDFFF, 16'h0000, 16'h0000, 1'b1};
    vec[7] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1};
    vec[8] = '{1'b1, 1'b0, 16'hEFFF, 16'h0000, 16'h0001, 1'b1};

    reset = 1'b1; io_rd = 1'b0; io_wr = 1'b0; io_addr = 16'h0; io_wdata = 16'h0; uart_rx = 1'b1;
    tick(3);
    check("reset_io_din", io_din, 16'h0000);
    check("reset_tx", {15'b0, uart_tx}, 16'h0001);
    reset = 1'b0;
    tick(2);

    for (int i = 0; i < NV; i++) begin
      io_rd = vec[i].rd; io_wr = vec[i].wr; io_addr = vec[i].addr; io_wdata = vec[i].wdata;
      if (vec[i].rd) expect_rd($sformatf("vec%0d_din", i), vec[i].exp_din);
      @(negedge clk);
      io_rd = 1'b0; io_wr = 1'b0; io_addr = 16'h0;
      check($sformatf("vec%0d_tx", i), {15'b0, uart_tx}, {15'b0, vec[i].exp_tx});
    end
    tick(2);
    check("io_din_hold", io_din, 16'h0001);

    // TX frame 0xA5 started by a simultaneous DATA read (empty) and DATA write
    expect_rd("rdwr_data_empty", 16'h0000);
    io_rd = 1'b1; io_wr = 1'b1; io_addr = 16'h1000; io_wdata = 16'h00A5;
    @(negedge clk);
    io_rd = 1'b0; io_wr = 1'b0; io_addr = 16'h0;
    frame = {1'b1, 8'hA5, 1'b0};
    for (int i = 1; i <= 40; i++) begin
      check($sformatf("tx_a5_c%0d", i), {15'b0, uart_tx}, {15'b0, frame[(i-1)/4]});
      io_wr    = (i == 5);
      io_rd    = (i == 10);
      io_addr  = (i == 5) ? 16'h1000 : ((i == 10) ? 16'h2000 : 16'h0000);
      io_wdata = 16'h00FF;
      if (i == 10) expect_rd("tx_busy_status", 16'h0000);
      @(negedge clk);
    end
    io_rd = 1'b0; io_wr = 1'b0; io_addr = 16'h0;
    check("tx_idle_after", {15'b0, uart_tx}, 16'h0001);
    rd(16'h2000, 16'h0001, "tx_done_status");
    wr(16'h1000, 16'h005A);
    check("tx_b2b_start", {15'b0, uart_tx}, 16'h0000);
    tick(42);

    // RX single byte
    send_byte(8'h3C, 1'b1);
    rd(16'h2000, 16'h0003, "rx_status_avail");
    rd(16'h1000, 16'h003C, "rx_data_3c");
    rd(16'h2000, 16'h0001, "rx_status_empty");
    rd(16'h1000, 16'h0000, "rx_data_empty");

    // Overrun: 9 bytes into an 8-deep FIFO
    for (int b = 1; b <= 9; b++) send_byte(8'(b), 1'b1);
    rd(16'h2000, 16'h0007, "ovr_status");
    for (int b = 1; b <= 8; b++) rd(16'h1000, 16'(b), $sformatf("ovr_data%0d", b));
    rd(16'h2000, 16'h0001, "ovr_cleared");
    rd(16'h1000, 16'h0000, "ovr_fifo_empty");

    // Framing error, then glitch
    send_byte(8'h55, 1'b0);
    tick(6);
    rd(16'h2000, 16'h0009, "frm_status");
    rd(16'h1000, 16'h0000, "frm_no_byte");
    rd(16'h2000, 16'h0001, "frm_cleared");
    uart_rx = 1'b0;
    tick(1);
    uart_rx = 1'b1;
    tick(12);
    rd(16'h2000, 16'h0001, "glitch_status");
    rd(16'h1000, 16'h0000, "glitch_no_byte");

    // Reset 15 cycles into a frame of 0x00
    rd(16'h2000, 16'h0001, "pre_reset_status");
    wr(16'h1000, 16'h0000);
    tick(14);
    check("mid_frame_tx_low", {15'b0, uart_tx}, 16'h0000);
    reset = 1'b1;
    @(negedge clk);
    check("reset_abort_tx", {15'b0, uart_tx}, 16'h0001);
    check("reset_abort_din", io_din, 16'h0000);
    reset = 1'b0;
    tick(1);
    rd(16'h2000, 16'h0001, "post_reset_status");
    tick(40);
    check("post_reset_tx_idle", {15'b0, uart_tx}, 16'h0001);

    tick(2);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_leftover: got %0d pending reads expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
